// File: rtl/mem_datos_mc.sv
// Data-memory responder for the multicycle RV32 core: word/byte load-store
// with programmable wait states, a one-cycle ready pulse and a fault flag.
module mem_datos_mc #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic        stype,
   input  logic        ltype,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int DEPTH = 1 << (ADDR_W - 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic [31:0] addr_q, wdata_q;
   logic        we_q, size_q;
   logic        err_q;
   logic        access;
   logic        fault;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-3:0] idx;
   logic [1:0]        lane;
   logic [31:0]       word;
   logic [7:0]        lane_byte;

   assign idx       = addr_q[ADDR_W-1:2];
   assign lane      = addr_q[1:0];
   assign word      = mem[idx];
   assign lane_byte = word[8*lane +: 8];

   // size_q=0 means a word access; byte accesses only fault out of range
   assign fault = (addr_q[31:ADDR_W] != '0)
               || (!size_q && (lane != 2'b00));

   always_comb begin
      state_nx = state;
      access   = 1'b0;
      unique case (state)
         IDLE: if (req) state_nx = BUSY;
         BUSY: begin
            if (cnt == 4'd0) begin
               access   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata   <= 32'd0;
         err_q   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
         size_q  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            size_q  <= we ? stype : ltype;
            cnt     <= 4'(WAIT);
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (access) begin
            err_q <= fault;
            if (!fault && !we_q)
               rdata <= size_q ? {24'd0, lane_byte} : word;
         end
      end
   end

   // Storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (access && !fault && we_q) begin
         if (size_q)
            mem[idx][8*lane +: 8] <= wdata_q[7:0];
         else
            mem[idx] <= wdata_q;
      end
   end

   assign ready = (state == DONE);
   assign busy  = (state != IDLE);
   assign err   = ready & err_q;

endmodule

// File: tb/tb_mem_datos_mc.sv
// Bench for mem_datos_mc: WAIT=2 and WAIT=0 instances checked every cycle
// against a transaction-timeline model, plus literal spot checks.
module tb_mem_datos_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic        we    [2];
   logic        stype [2];
   logic        ltype [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        ready [2];
   logic        busy  [2];
   logic        err   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_datos_mc #(.ADDR_W(10), .WAIT(2)) u0 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we[0]),
      .stype(stype[0]), .ltype(ltype[0]), .addr(addr[0]),
      .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
      .busy(busy[0]), .err(err[0])
   );

   mem_datos_mc #(.ADDR_W(10), .WAIT(0)) u1 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we[1]),
      .stype(stype[1]), .ltype(ltype[1]), .addr(addr[1]),
      .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
      .busy(busy[1]), .err(err[1])
   );

   function automatic int wv(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: age = edges since acceptance, -1 when idle
   int          age    [2];
   logic [31:0] mm     [2][256];
   logic        m_we   [2];
   logic        m_sz   [2];
   logic [31:0] m_a    [2];
   logic [31:0] m_d    [2];
   logic [31:0] exp_rd [2];
   logic        exp_er [2];

   task automatic model_access(input int i);
      logic        flt;
      logic [31:0] w;
      int          ix, ln;
      flt = ((m_a[i] >> 10) != 0) || (!m_sz[i] && m_a[i][1:0] != 2'b00);
      exp_er[i] = flt;
      ix = int'(m_a[i][9:2]);
      ln = int'(m_a[i][1:0]);
      w  = mm[i][ix];
      if (!flt) begin
         if (m_we[i]) begin
            if (m_sz[i]) w[8*ln +: 8] = m_d[i][7:0];
            else w = m_d[i];
            mm[i][ix] = w;
         end else begin
            exp_rd[i] = m_sz[i] ? {24'd0, w[8*ln +: 8]} : w;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            age[i]    = -1;
            exp_rd[i] = 32'd0;
            exp_er[i] = 1'b0;
         end else if (age[i] < 0) begin
            if (req[i]) begin
               age[i]  = 0;
               m_we[i] = we[i];
               m_sz[i] = we[i] ? stype[i] : ltype[i];
               m_a[i]  = addr[i];
               m_d[i]  = wdata[i];
            end
         end else begin
            age[i]++;
            if (age[i] == wv(i) + 1) model_access(i);
            else if (age[i] == wv(i) + 2) age[i] = -1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         logic er, rd;
         rd = (age[i] == wv(i) + 1);
         er = rd && exp_er[i];
         chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(rd));
         chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(age[i] >= 0));
         chk($sformatf("err%0d", i), 32'(err[i]), 32'(er));
         chk($sformatf("rdata%0d", i), rdata[i], exp_rd[i]);
      end
   end

   // Enter and leave on a falling edge
   task automatic do_acc(input int i, input logic w, input logic sz,
                         input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      while (busy[i] && n < 20) begin
         @(negedge clk);
         n++;
      end
      req[i] = 1'b1; we[i] = w; stype[i] = sz; ltype[i] = sz;
      addr[i] = a; wdata[i] = d;
      @(negedge clk);
      req[i] = 1'b0; addr[i] = ~a; wdata[i] = ~d;
      stype[i] = ~sz; ltype[i] = ~sz;
      n = 1;
      while (!ready[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("latency%0d", i), 32'(n), 32'(wv(i) + 2));
   endtask

   initial begin
      logic [31:0] tbl [4];
      int          cnt [2];
      tbl = '{32'h10, 32'h14, 32'h12, 32'h17};
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; we[i] = 0; stype[i] = 0; ltype[i] = 0;
         addr[i] = 0; wdata[i] = 0;
      end
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_ready", 32'(ready[0]), 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
      rst = 1'b1;
      @(negedge clk);

      do_acc(0, 1, 0, 32'h10, 32'h12345678);
      chk("sw_err", 32'(err[0]), 32'd0);
      do_acc(0, 0, 0, 32'h10, 32'h0);
      chk("lw_10", rdata[0], 32'h12345678);

      do_acc(0, 1, 1, 32'h11, 32'h000000AB);
      do_acc(0, 0, 0, 32'h10, 32'h0);
      chk("lw_after_sb", rdata[0], 32'h1234AB78);
      do_acc(0, 0, 1, 32'h11, 32'h0);
      chk("lbu_11", rdata[0], 32'h000000AB);
      do_acc(0, 0, 1, 32'h13, 32'h0);
      chk("lbu_13", rdata[0], 32'h00000012);

      do_acc(0, 0, 0, 32'h12, 32'h0);
      chk("mis_lw_err", 32'(err[0]), 32'd1);
      chk("mis_lw_hold", rdata[0], 32'h00000012);
      do_acc(0, 1, 0, 32'h12, 32'hFFFFFFFF);
      chk("mis_sw_err", 32'(err[0]), 32'd1);
      do_acc(0, 1, 0, 32'h80000010, 32'hFFFFFFFF);
      chk("hi_sw_err", 32'(err[0]), 32'd1);
      do_acc(0, 0, 0, 32'h10, 32'h0);
      chk("word_kept", rdata[0], 32'h1234AB78);

      do_acc(0, 1, 0, 32'h0, 32'h11111111);
      do_acc(0, 0, 0, 32'h400, 32'h0);
      chk("oor_lw_err", 32'(err[0]), 32'd1);
      do_acc(0, 1, 1, 32'h400, 32'h000000EE);
      chk("oor_sb_err", 32'(err[0]), 32'd1);
      do_acc(0, 0, 0, 32'h0, 32'h0);
      chk("oor_nowrite", rdata[0], 32'h11111111);
      do_acc(0, 1, 1, 32'h3FF, 32'h0000005A);
      do_acc(0, 0, 1, 32'h3FF, 32'h0);
      chk("lbu_3ff", rdata[0], 32'h0000005A);
      chk("lbu_3ff_err", 32'(err[0]), 32'd0);

      do_acc(0, 1, 0, 32'h14, 32'h0BADF00D);
      do_acc(1, 1, 0, 32'h10, 32'hA5A5A5A5);
      do_acc(1, 1, 0, 32'h14, 32'h5A5A5A5A);
      do_acc(1, 1, 1, 32'h17, 32'h0000003C);
      do_acc(1, 0, 0, 32'h10, 32'h0);
      chk("w0_lw_10", rdata[1], 32'hA5A5A5A5);
      @(negedge clk);

      cnt = '{0, 0};
      for (int k = 0; k < 15; k++) begin
         for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; stype[i] = 1'b0;
            ltype[i] = (k % 3) == 1;
            addr[i] = tbl[k % 4];
         end
         @(negedge clk);
         for (int i = 0; i < 2; i++) if (ready[i]) cnt[i]++;
      end
      req[0] = 1'b0;
      req[1] = 1'b0;
      repeat (10) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) if (ready[i]) cnt[i]++;
      end
      chk("held_cnt0", 32'(cnt[0]), 32'd3);
      chk("held_cnt1", 32'(cnt[1]), 32'd5);

      do_acc(0, 1, 0, 32'h20, 32'hCAFEF00D);
      do_acc(0, 0, 0, 32'h20, 32'h0);
      chk("lw_20", rdata[0], 32'hCAFEF00D);
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; stype[0] = 1'b0;
      addr[0] = 32'h20; wdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_ready", 32'(ready[0]), 32'd0);
      chk("abort_rdata", rdata[0], 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_acc(0, 0, 0, 32'h20, 32'h0);
      chk("abort_kept", rdata[0], 32'hCAFEF00D);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
